// File: rtl/mem_io_responder_pkg.sv
// Shared definitions for the memory/IO responder: IO window decode constants
// (the values the memory controller also uses for its io_buffer_full check)
// and the address classification helper.
package mem_io_responder_pkg;

  localparam logic [1:0]  IO_SEL_BITS     = 2'b11;
  localparam logic [17:0] IO_UART_ADDR    = 18'h30000;
  localparam logic [17:0] IO_HALT_ADDR    = 18'h30004;
  localparam logic [7:0]  IO_READ_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ACC_RAM      = 2'd0,
    ACC_UART     = 2'd1,
    ACC_HALT     = 2'd2,
    ACC_IO_OTHER = 2'd3
  } acc_kind_e;

  // Classify the decoded 18-bit byte address into RAM or one of the IO targets.
  function automatic acc_kind_e decode_addr(input logic [17:0] addr);
    acc_kind_e kind;
    if (addr[17:16] != IO_SEL_BITS) begin
      kind = ACC_RAM;
    end else begin
      case (addr)
        IO_UART_ADDR: kind = ACC_UART;
        IO_HALT_ADDR: kind = ACC_HALT;
        default:      kind = ACC_IO_OTHER;
      endcase
    end
    return kind;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: power-of-two circular byte queue with occupancy count.
// Pushes while full and pops while empty are ignored; dout shows the head.
module byte_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic [AW:0] count,
  output logic        empty,
  output logic        full
);

  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_DEPTH);
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Next pointers and count; pointers wrap naturally at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus IO window (UART TX queue, halt flag,
// optional RX holding register) on the controller's byte-wide memory bus.
// Optional feature macro: IO_RX_EN enables the one-byte RX holding register.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        sim_halt,
  output logic        txq_overflow
);

  localparam int            CW        = $clog2(TXQ_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_MARK = CW'(TXQ_DEPTH - 2);

  logic [7:0]        ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_addr_s;
  acc_kind_e         acc_kind_s;
  logic              ram_we_s, uart_wr_s, uart_rd_s, halt_wr_s;
  logic [7:0]        mem_din_q, mem_din_d;
  logic [7:0]        rx_rd_byte_s;
  logic              sim_halt_q, txq_overflow_q;
  logic [CW-1:0]     txq_count_s;
  logic              txq_empty_s, txq_full_s;

  assign ram_addr_s = mem_a[RAM_AW-1:0];

  // Address decode into one access strobe per target.
  always_comb begin
    acc_kind_s = decode_addr(mem_a[17:0]);
    ram_we_s   = 1'b0;
    uart_wr_s  = 1'b0;
    uart_rd_s  = 1'b0;
    halt_wr_s  = 1'b0;
    case (acc_kind_s)
      ACC_RAM:  ram_we_s  = mem_wr;
      ACC_UART: begin
        uart_wr_s = mem_wr;
        uart_rd_s = !mem_wr;
      end
      ACC_HALT: halt_wr_s = mem_wr;
      default:  ram_we_s  = 1'b0;
    endcase
  end

  // Byte RAM write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_addr_s] <= mem_dout;
    end
  end

`ifdef IO_RX_EN
  logic [7:0] rx_q;
  logic       rx_full_q;

  assign rx_rd_byte_s = rx_full_q ? rx_q : IO_READ_DEFAULT;

  // RX holding register: a new byte always wins over a read-clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q      <= 8'h00;
      rx_full_q <= 1'b0;
    end else if (rx_valid) begin
      rx_q      <= rx_data;
      rx_full_q <= 1'b1;
    end else if (uart_rd_s) begin
      rx_full_q <= 1'b0;
    end else begin
      rx_full_q <= rx_full_q;
    end
  end
`else
  logic unused_rx_s;
  assign unused_rx_s  = ^{rx_data, rx_valid};
  assign rx_rd_byte_s = IO_READ_DEFAULT;
`endif

  // Read data select; write cycles hold the previous byte.
  always_comb begin
    mem_din_d = mem_din_q;
    if (!mem_wr) begin
      case (acc_kind_s)
        ACC_RAM:  mem_din_d = ram_q[ram_addr_s];
        ACC_UART: mem_din_d = rx_rd_byte_s;
        default:  mem_din_d = IO_READ_DEFAULT;
      endcase
    end else begin
      mem_din_d = mem_din_q;
    end
  end

  // Read data register and sticky status flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din_q      <= 8'h00;
      sim_halt_q     <= 1'b0;
      txq_overflow_q <= 1'b0;
    end else begin
      mem_din_q      <= mem_din_d;
      sim_halt_q     <= sim_halt_q | halt_wr_s;
      txq_overflow_q <= txq_overflow_q | (uart_wr_s & txq_full_s);
    end
  end

  byte_fifo #(.DEPTH(TXQ_DEPTH)) u_txq (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (uart_wr_s),
    .pop   (tx_ready),
    .din   (mem_dout),
    .dout  (tx_data),
    .count (txq_count_s),
    .empty (txq_empty_s),
    .full  (txq_full_s)
  );

  logic unused_addr_s;
  assign unused_addr_s = ^mem_a[31:18];

  assign mem_din        = mem_din_q;
  assign tx_valid       = !txq_empty_s;
  assign io_buffer_full = (txq_count_s >= FULL_MARK);
  assign sim_halt       = sim_halt_q;
  assign txq_overflow   = txq_overflow_q;

endmodule
